// File: rtl/lcd_panel_rx.sv
// rtl/lcd_panel_rx.sv - DMG LCD pin receiver: rebuilds pixel, line and frame events from panel pins
module lcd_panel_rx #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 144
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pin_cp,
    input  logic       pin_cpl,
    input  logic       pin_fr,
    input  logic       pin_st,
    input  logic       pin_s,
    input  logic [1:0] pin_ld,
    output logic       pix_valid,
    output logic [7:0] pix_x,
    output logic [7:0] pix_y,
    output logic [1:0] pix_data,
    output logic       line_done,
    output logic [7:0] line_len,
    output logic       line_fr,
    output logic       frame_done,
    output logic [7:0] frame_lines,
    output logic       err_short,
    output logic       err_long,
    output logic       err_vsize,
    output logic       in_frame
);

    typedef enum logic {WAIT_S, ACTIVE} state_t;

    localparam logic [7:0] W8 = 8'(WIDTH);
    localparam logic [7:0] H8 = 8'(HEIGHT);
    localparam logic [8:0] H9 = 9'(HEIGHT);

    // Packed pin vector: {cp, cpl, fr, st, s, ld[1:0]}
    localparam int B_CP  = 6;
    localparam int B_CPL = 5;
    localparam int B_FR  = 4;
    localparam int B_ST  = 3;
    localparam int B_S   = 2;

    logic [6:0] a_q, b_q;
    state_t     state_q, state_d;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic       pix_valid_q, pix_valid_d;
    logic [7:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [1:0] pix_data_q, pix_data_d;
    logic       line_done_q, line_done_d;
    logic [7:0] line_len_q, line_len_d;
    logic       line_fr_q, line_fr_d;
    logic       frame_done_q, frame_done_d;
    logic [7:0] frame_lines_q, frame_lines_d;
    logic       err_short_q, err_short_d;
    logic       err_long_q, err_long_d;
    logic       err_vsize_q, err_vsize_d;

    logic       cp_fall, cpl_rise, st_rise;
    logic [7:0] x_end;
    logic [8:0] y_inc;
    logic [7:0] y_next;

    assign cp_fall  = b_q[B_CP] & ~a_q[B_CP];
    assign cpl_rise = a_q[B_CPL] & ~b_q[B_CPL];
    assign st_rise  = a_q[B_ST] & ~b_q[B_ST];
    assign y_inc    = {1'b0, y_q} + 9'd1;
    assign y_next   = (y_q == 8'hFF) ? 8'hFF : y_inc[7:0];

    // Next-state: pixel on CP fall first, then line/frame close-out on CPL rise using the updated x
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        x_end         = x_q;
        pix_valid_d   = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_data_d    = pix_data_q;
        line_done_d   = 1'b0;
        line_len_d    = line_len_q;
        line_fr_d     = line_fr_q;
        frame_done_d  = 1'b0;
        frame_lines_d = frame_lines_q;
        err_short_d   = err_short_q;
        err_long_d    = err_long_q;
        err_vsize_d   = err_vsize_q;

        if (state_q == ACTIVE && cp_fall) begin
            if (x_q < W8) begin
                pix_valid_d = 1'b1;
                pix_x_d     = x_q;
                pix_y_d     = y_q;
                pix_data_d  = b_q[1:0];
                x_end       = x_q + 8'd1;
            end else begin
                err_long_d = 1'b1;
            end
        end
        x_d = x_end;

        if (cpl_rise) begin
            case (state_q)
                WAIT_S: begin
                    if (a_q[B_S]) begin
                        state_d = ACTIVE;
                        x_d     = 8'd0;
                        y_d     = 8'd0;
                    end
                end
                ACTIVE: begin
                    line_done_d = 1'b1;
                    line_len_d  = x_end;
                    line_fr_d   = a_q[B_FR];
                    x_d         = 8'd0;
                    if (x_end != W8) err_short_d = 1'b1;
                    if (a_q[B_S]) begin
                        frame_done_d  = 1'b1;
                        frame_lines_d = y_inc[7:0];
                        if (y_inc != H9) err_vsize_d = 1'b1;
                        y_d = 8'd0;
                    end else begin
                        y_d = y_next;
                        if (y_next == H8) err_vsize_d = 1'b1;
                    end
                end
                default: state_d = WAIT_S;
            endcase
        end

        // ST is only a consistency monitor: a sync mid-line means the line was cut short
        if (st_rise && x_q != 8'd0 && x_q != W8) err_short_d = 1'b1;
    end

    // Pin synchronisation stages, state and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q           <= '0;
            b_q           <= '0;
            state_q       <= WAIT_S;
            x_q           <= '0;
            y_q           <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            line_done_q   <= 1'b0;
            line_len_q    <= '0;
            line_fr_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_lines_q <= '0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_vsize_q   <= 1'b0;
        end else begin
            a_q           <= {pin_cp, pin_cpl, pin_fr, pin_st, pin_s, pin_ld};
            b_q           <= a_q;
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            line_done_q   <= line_done_d;
            line_len_q    <= line_len_d;
            line_fr_q     <= line_fr_d;
            frame_done_q  <= frame_done_d;
            frame_lines_q <= frame_lines_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_vsize_q   <= err_vsize_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign line_done   = line_done_q;
    assign line_len    = line_len_q;
    assign line_fr     = line_fr_q;
    assign frame_done  = frame_done_q;
    assign frame_lines = frame_lines_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign err_vsize   = err_vsize_q;
    assign in_frame    = (state_q == ACTIVE);

endmodule

// File: tb/tb_lcd_panel_rx.sv
// tb/tb_lcd_panel_rx.sv - directed bench for lcd_panel_rx with event-level reference model
module tb_lcd_panel_rx;

    localparam int W = 160;
    localparam int H = 144;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pin_cp = 1'b0, pin_cpl = 1'b0, pin_fr = 1'b0, pin_st = 1'b0, pin_s = 1'b0;
    logic [1:0] pin_ld = 2'd0;
    logic       pix_valid, line_done, line_fr, frame_done;
    logic [7:0] pix_x, pix_y, line_len, frame_lines;
    logic [1:0] pix_data;
    logic       err_short, err_long, err_vsize, in_frame;

    lcd_panel_rx #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset(reset),
        .pin_cp(pin_cp), .pin_cpl(pin_cpl), .pin_fr(pin_fr), .pin_st(pin_st),
        .pin_s(pin_s), .pin_ld(pin_ld),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .line_done(line_done), .line_len(line_len), .line_fr(line_fr),
        .frame_done(frame_done), .frame_lines(frame_lines),
        .err_short(err_short), .err_long(err_long), .err_vsize(err_vsize),
        .in_frame(in_frame)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int d; } pix_t;
    typedef struct { int len; int fr; } line_t;

    int total = 0;
    int bad = 0;

    // Reference model: receiver as seen at the level of whole pin events
    bit    m_active;
    int    m_x, m_y;
    bit    m_es, m_el, m_ev;
    pix_t  exp_pix[$];
    line_t exp_line[$];
    int    exp_frame[$];

    int pix_cnt = 0, line_cnt = 0, frame_cnt = 0, fr_ones = 0;
    int last_px_x = -1, last_px_y = -1, last_px_d = -1, last_len = -1, last_flines = -1;
    int snap;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_x = 0; m_y = 0;
        m_es = 1'b0; m_el = 1'b0; m_ev = 1'b0;
    endtask

    task automatic model_pixel(input int ld);
        if (m_active) begin
            if (m_x < W) begin
                exp_pix.push_back('{x: m_x, y: m_y, d: ld});
                m_x++;
            end else begin
                m_el = 1'b1;
            end
        end
    endtask

    task automatic model_line(input bit s, input bit fr);
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1; m_x = 0; m_y = 0;
            end
        end else begin
            exp_line.push_back('{len: m_x, fr: int'(fr)});
            if (m_x != W) m_es = 1'b1;
            m_x = 0;
            if (s) begin
                exp_frame.push_back(m_y + 1);
                if (m_y + 1 != H) m_ev = 1'b1;
                m_y = 0;
            end else begin
                m_y = (m_y >= 255) ? 255 : m_y + 1;
                if (m_y == H) m_ev = 1'b1;
            end
        end
    endtask

    task automatic cp_pulse(input int ld);
        pin_ld = 2'(ld);
        pin_cp = 1'b1;
        tick();
        pin_cp = 1'b0;
        model_pixel(ld);
        tick();
    endtask

    task automatic cpl_pulse(input bit s, input bit fr, input bit with_pix, input int ld);
        if (with_pix) begin
            pin_ld = 2'(ld);
            pin_cp = 1'b1;
            tick();
            pin_cp = 1'b0;
            model_pixel(ld);
        end
        pin_s = s;
        pin_fr = fr;
        pin_cpl = 1'b1;
        model_line(s, fr);
        tick();
        pin_cpl = 1'b0;
        pin_s = 1'b0;
        tick();
    endtask

    task automatic st_pulse();
        pin_st = 1'b1;
        if (m_x != 0 && m_x != W) m_es = 1'b1;
        tick();
        pin_st = 1'b0;
        tick();
    endtask

    task automatic settle();
        repeat (4) tick();
        check("pending_pix", 64'(exp_pix.size()), 64'd0);
        check("pending_line", 64'(exp_line.size()), 64'd0);
        check("pending_frame", 64'(exp_frame.size()), 64'd0);
    endtask

    task automatic check_flags();
        check("flags_vs_model", {61'd0, err_short, err_long, err_vsize}, {61'd0, m_es, m_el, m_ev});
    endtask

    task automatic check_reset_outputs();
        check("reset_data_outs", {22'd0, pix_x, pix_y, pix_data, line_len, frame_lines}, 64'd0);
        check("reset_bit_outs", {56'd0, pix_valid, line_done, line_fr, frame_done,
                                 err_short, err_long, err_vsize, in_frame}, 64'd0);
    endtask

    task automatic mon_step();
        pix_t  ep;
        line_t el;
        int    ef;
        if (pix_valid === 1'b1) begin
            pix_cnt++;
            last_px_x = int'(pix_x); last_px_y = int'(pix_y); last_px_d = int'(pix_data);
            if (exp_pix.size() == 0) begin
                check("pix_unexpected", 64'(pix_valid), 64'd0);
            end else begin
                ep = exp_pix.pop_front();
                check("pix_xyd", {46'd0, pix_x, pix_y, pix_data},
                      {46'd0, 8'(ep.x), 8'(ep.y), 2'(ep.d)});
            end
        end
        if (line_done === 1'b1) begin
            line_cnt++;
            last_len = int'(line_len);
            if (line_fr === 1'b1) fr_ones++;
            if (exp_line.size() == 0) begin
                check("line_unexpected", 64'(line_done), 64'd0);
            end else begin
                el = exp_line.pop_front();
                check("line_len_fr", {55'd0, line_len, line_fr}, {55'd0, 8'(el.len), 1'(el.fr)});
            end
        end
        if (frame_done === 1'b1) begin
            frame_cnt++;
            last_flines = int'(frame_lines);
            if (exp_frame.size() == 0) begin
                check("frame_unexpected", 64'(frame_done), 64'd0);
            end else begin
                ef = exp_frame.pop_front();
                check("frame_lines", 64'(frame_lines), 64'(ef));
            end
        end
    endtask

    initial begin
        model_reset();
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset state
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check_reset_outputs();

        // CP activity before any frame start is ignored
        for (int i = 0; i < 30; i++) cp_pulse(1);
        settle();
        check("pre_s_pix_cnt", 64'(pix_cnt), 64'd0);
        check("pre_s_in_frame", 64'(in_frame), 64'd0);
        cpl_pulse(1'b1, 1'b0, 1'b0, 0);
        settle();
        check("start_in_frame", 64'(in_frame), 64'd1);
        check("start_no_line", 64'(line_cnt), 64'd0);

        // Full nominal frame, LD = x mod 4; last CPL carries S
        for (int l = 0; l < H; l++) begin
            for (int i = 0; i < W; i++) cp_pulse(i % 4);
            cpl_pulse(l == H - 1, 1'b0, 1'b0, 0);
        end
        settle();
        check("f1_pix_cnt", 64'(pix_cnt), 64'd23040);
        check("f1_line_cnt", 64'(line_cnt), 64'd144);
        check("f1_last_pix", {40'd0, 8'(last_px_x), 8'(last_px_y), 8'(last_px_d)}, {40'd0, 8'd159, 8'd143, 8'd3});
        check("f1_line_len", 64'(last_len), 64'd160);
        check("f1_frame", {32'(frame_cnt), 32'(last_flines)}, {32'd1, 32'd144});
        check("f1_no_errors", {61'd0, err_short, err_long, err_vsize}, 64'd0);
        check_flags();

        // Frame 2, line 0: final CP fall coincides with CPL rise
        for (int i = 0; i < W - 1; i++) cp_pulse(i % 4);
        cpl_pulse(1'b0, 1'b0, 1'b1, 3);
        settle();
        check("sim_last_pix_x", 64'(last_px_x), 64'd159);
        check("sim_line_len", 64'(last_len), 64'd160);
        check("sim_no_short", 64'(err_short), 64'd0);
        check_flags();

        // Line 1: one CP too many
        for (int i = 0; i < W + 1; i++) cp_pulse(i % 4);
        cpl_pulse(1'b0, 1'b1, 1'b0, 0);
        settle();
        check("long_err", 64'(err_long), 64'd1);
        check("long_line_len", 64'(last_len), 64'd160);
        check("long_no_short", 64'(err_short), 64'd0);

        // Line 2: one CP too few
        for (int i = 0; i < W - 1; i++) cp_pulse(i % 4);
        cpl_pulse(1'b0, 1'b0, 1'b0, 0);
        settle();
        check("short_line_len", 64'(last_len), 64'd159);
        check("short_err", 64'(err_short), 64'd1);
        check_flags();

        // Lines 3..98 short, FR toggling by line index
        for (int l = 3; l < 99; l++) begin
            for (int i = 0; i < 4; i++) cp_pulse(i % 4);
            cpl_pulse(1'b0, 1'(l % 2), 1'b0, 0);
        end
        settle();
        check("pre_vsize", 64'(err_vsize), 64'd0);

        // Line 99 closes a 100-line frame
        for (int i = 0; i < 4; i++) cp_pulse(i % 4);
        cpl_pulse(1'b1, 1'b1, 1'b0, 0);
        settle();
        check("f2_frame_lines", 64'(last_flines), 64'd100);
        check("f2_vsize", 64'(err_vsize), 64'd1);
        check("f2_fr_ones", 64'(fr_ones), 64'd50);
        check_flags();

        // Frame 3: advance to y = 50, x = 80, then reset mid-line
        for (int l = 0; l < 50; l++) cpl_pulse(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 80; i++) cp_pulse(i % 4);
        settle();
        check("mid_pix_xy", {48'd0, 8'(last_px_x), 8'(last_px_y)}, {48'd0, 8'd79, 8'd50});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check_reset_outputs();

        snap = pix_cnt;
        for (int i = 0; i < 10; i++) cp_pulse(1);
        settle();
        check("post_rst_no_pix", 64'(pix_cnt), 64'(snap));
        check("post_rst_in_frame", 64'(in_frame), 64'd0);
        cpl_pulse(1'b1, 1'b0, 1'b0, 0);
        settle();
        check("restart_in_frame", 64'(in_frame), 64'd1);

        // ST at x = 0 is legal; ST mid-line flags a short line
        st_pulse();
        settle();
        check("st_at_x0", 64'(err_short), 64'd0);
        cp_pulse(2);
        st_pulse();
        settle();
        check("st_mid_line", 64'(err_short), 64'd1);
        check("restart_pix", {40'd0, 8'(last_px_x), 8'(last_px_y), 8'(last_px_d)}, {40'd0, 8'd0, 8'd0, 8'd2});
        check_flags();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_panel_rx.md
Name: lcd_panel_rx

Overview:
- Behavioural LCD panel receiver: the consuming end of the DMG LCD pin interface.
- Samples the panel pins CP, CPL, ST, S, FR and LD[1:0] in the system clock domain.
- Reconstructs pixel writes (x, y, 2-bit shade) plus line and frame events, and flags timing violations.
- Sits in the testbench/top level, attached to the LCD pins of the CPU model; feeds screen dumps and checkers.

Parameters:
- WIDTH, 160, pixels per line expected between line latches.
- HEIGHT, 144, lines expected per frame.

Ports:
- clk  in  1  system clock; all pins are sampled on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pin_cp  in  1  pixel clock (clkpipe); LD is captured on its falling edge.
- pin_cpl  in  1  line latch, active-high level (inverse of npin_cpl).
- pin_fr  in  1  frame polarity, active-high level (inverse of npin_fr).
- pin_st  in  1  horizontal sync, active-high level (inverse of npin_st).
- pin_s  in  1  vertical sync, active-high level (inverse of npin_s).
- pin_ld  in  2  pixel data.
- pix_valid  out  1  one-cycle strobe for a captured pixel.
- pix_x  out  8  column of the captured pixel.
- pix_y  out  8  row of the captured pixel.
- pix_data  out  2  shade of the captured pixel.
- line_done  out  1  one-cycle strobe on a CPL rising edge.
- line_len  out  8  pixel count of the completed line; held until the next line_done.
- line_fr  out  1  pin_fr sampled at the CPL rising edge.
- frame_done  out  1  one-cycle strobe when a new frame starts after at least one line.
- frame_lines  out  8  line count of the completed frame; held until the next frame_done.
- err_short  out  1  sticky: a line completed with line_len != WIDTH.
- err_long  out  1  sticky: CP falling edge while x == WIDTH.
- err_vsize  out  1  sticky: frame_lines != HEIGHT, or a line started while y == HEIGHT.
- in_frame  out  1  high while state is ACTIVE.

Behaviour:
- Input sampling
  - Every pin is registered once (stage A); stage A is copied to stage B each cycle.
  - An edge exists in a cycle when A != B.
  - All outputs are registered. Latency is 2 clk edges from the first edge at which the new pin level is present.
- State machine, two states:
  - WAIT_S: waits for the first S-high at a CPL rising edge. CP edges are ignored. All strobes stay 0.
  - ACTIVE: capturing.
- Transition WAIT_S -> ACTIVE: CPL rising edge with S (stage A) = 1. Set y = 0, x = 0. No line_done. in_frame goes 1.
- CP falling edge in ACTIVE:
  - If x < WIDTH: pix_valid = 1, pix_x = x, pix_y = y, pix_data = LD (stage B value), then x++.
  - If x == WIDTH: no pix_valid, set err_long, x saturates at WIDTH.
- CPL rising edge in ACTIVE:
  - line_done = 1, line_len = x, line_fr = FR; x = 0.
  - err_short is set if x != WIDTH.
  - If S = 1: frame_done = 1, frame_lines = y + 1; set err_vsize if y + 1 != HEIGHT; y = 0.
  - If S = 0: y++, saturating at 255. If the new y == HEIGHT, set err_vsize.
- Simultaneous CP fall and CPL rise in the same cycle: the pixel is processed first (counted in the ending line at the old x). Then line and frame handling uses x + 1.
- pin_st is monitored only. A rising edge of ST while x != 0 and x != WIDTH sets err_short; no other effect.
- Reset values:
  - State = WAIT_S.
  - x, y, pix_*, line_len, frame_lines = 0.
  - line_fr = 0; all strobes and error flags = 0; in_frame = 0.
  - Stage A and B registers = 0.
- Reset mid-line: discards all progress. The first CP falling edge after reset never produces a pixel until S is seen.
- Error flags clear only on reset.

Test Plan:
- Reset, then drive one frame: S high over the first CPL, 144 lines of 160 CP pulses, LD = x mod 4 -> 23040 pix_valid strobes, the last with x = 159, y = 143, data = 3. 144 line_done strobes with line_len = 160. On the next S+CPL: frame_done = 1, frame_lines = 144, no error flag.
- 30 CP pulses before any S/CPL -> no pix_valid, in_frame = 0. The following S+CPL enters ACTIVE with x = 0, y = 0.
- Line with 161 CP pulses -> 160 pixels, err_long = 1, line_len = 160. Then a line with 159 pulses -> line_len = 159, err_short = 1.
- CP fall and CPL rise in the same clk cycle at x = 159 -> pix_valid with pix_x = 159, then line_done with line_len = 160, no err_short.
- Frame of 100 lines, then S+CPL -> frame_lines = 100, err_vsize = 1. Toggle FR each line -> line_fr alternates 0/1.
- Assert reset for 1 cycle at x = 80, y = 50 -> all outputs 0. The next CP edges are ignored until S+CPL.
